// File: rtl/instr_mem_loader.sv
// Byte-stream program loader for the instruction memory: parses length, data words and XOR checksum,
// issues one registered memory write per big-endian word and holds the CPU off until a valid image is in.
module instr_mem_loader #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(DEPTH);

    state_t      state;
    logic [7:0]  len_hi;
    logic [15:0] n_words;
    logic [7:0]  word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [7:0]  csum;
    logic        accept;
    logic [15:0] len_word;
    logic        last_word;

    always_comb begin
        byte_ready = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: byte_ready = 1'b1;
            default:                             byte_ready = 1'b0;
        endcase
    end

    assign accept    = byte_valid && byte_ready;
    assign len_word  = {len_hi, byte_in};
    // word_idx wraps at 256, so the last-word test is done in 16 bits against N
    assign last_word = (({8'd0, word_idx} + 16'd1) == n_words);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            len_hi   <= '0;
            n_words  <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            shift    <= '0;
            csum     <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_LEN_HI;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        csum     <= '0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_hi <= byte_in;
                        csum   <= csum ^ byte_in;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        n_words <= len_word;
                        csum    <= csum ^ byte_in;
                        if ({1'b0, len_word} > MAX_WORDS) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else if (len_word == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum     <= csum ^ byte_in;
                        shift    <= {shift[15:0], byte_in};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= {22'd0, word_idx, 2'b00};
                            wr_data  <= {shift, byte_in};
                            word_idx <= word_idx + 8'd1;
                            if (last_word) begin
                                state <= S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        if (byte_in == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader; expected writes and result come from
// a byte-array model of the image format (length, big-endian words, XOR checksum).
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    instr_mem_loader #(.DEPTH(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  img[$];
    logic [63:0] got_wr[$];
    logic [63:0] exp_wr[$];
    bit          exp_done;
    bit          exp_err;
    int          first_cyc = -1;
    int          done_cyc = -1;
    int          last_wr_cyc = -100;
    logic        done_q = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            check("wr_spacing", 64'(cyc - last_wr_cyc >= 4), 64'd1);
            last_wr_cyc = cyc;
            got_wr.push_back({wr_addr, wr_data});
        end
        if (done === 1'b1 && done_q !== 1'b1 && done_cyc < 0) done_cyc = cyc;
        done_q = done;
    end

    function automatic void build_model();
        int n;
        logic [7:0] x;
        exp_wr.delete();
        n = int'({img[0], img[1]});
        if (n > 256) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * n; i++) x ^= img[i];
        for (int w = 0; w < n; w++)
            exp_wr.push_back({32'((w % 256) * 4), img[2+4*w], img[3+4*w], img[4+4*w], img[5+4*w]});
        exp_done = (img[2+4*n] == x);
        exp_err  = !exp_done;
    endfunction

    task automatic make_image(input int n, input bit bad_sum, input bit idx_data);
        logic [7:0] x;
        logic [15:0] len;
        img.delete();
        len = 16'(n);
        img.push_back(len[15:8]);
        img.push_back(len[7:0]);
        if (n <= 256) begin
            for (int w = 0; w < n; w++) begin
                for (int b = 0; b < 4; b++) begin
                    if (idx_data) img.push_back((b == 3) ? 8'(w) : 8'h00);
                    else          img.push_back(8'($urandom_range(0, 255)));
                end
            end
            x = 8'h00;
            foreach (img[i]) x ^= img[i];
            if (bad_sum) x ^= 8'(1 << $urandom_range(0, 7));
            img.push_back(x);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int mode, output bit ok);
        int waited;
        waited = 0;
        ok = 1'b0;
        if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        start      = ($urandom_range(0, 7) == 0);
        while (byte_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (byte_ready === 1'b1) begin
            ok = 1'b1;
            if (first_cyc < 0) first_cyc = cyc;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load(input int mode, input string name);
        bit ok;
        int n;
        build_model();
        got_wr.delete();
        done_cyc  = -1;
        first_cyc = -1;
        pulse_start();
        check({name, "_start_ready"}, 64'(byte_ready), 64'd1);
        check({name, "_start_hold"}, 64'(cpu_hold), 64'd1);
        check({name, "_start_done"}, 64'(done), 64'd0);
        check({name, "_start_err"}, 64'(error), 64'd0);
        foreach (img[i]) begin
            send_byte(img[i], mode, ok);
            if (!ok) begin
                check({name, "_byte_timeout"}, 64'd0, 64'd1);
                break;
            end
        end
        check({name, "_done"}, 64'(done), 64'(exp_done));
        check({name, "_error"}, 64'(error), 64'(exp_err));
        check({name, "_hold"}, 64'(cpu_hold), 64'(exp_err));
        check({name, "_ready_end"}, 64'(byte_ready), 64'd0);
        repeat (2) @(negedge clk);
        check({name, "_wr_count"}, 64'(got_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check({name, "_wr"}, got_wr[i], exp_wr[i]);
        n = int'({img[0], img[1]});
        if (mode == 0 && exp_done)
            check({name, "_latency"}, 64'(done_cyc - first_cyc), 64'(4 * n + 3));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_hold", 64'(cpu_hold), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_ready", 64'(byte_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(byte_ready), 64'd0);

        img = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h06, 8'hC0, 8'h20, 8'h08, 8'h80, 8'h4D};
        load(0, "two");
        check("two_w0", (got_wr.size() > 0) ? got_wr[0] : 64'hX, {32'h000, 32'h20010006});
        check("two_w1", (got_wr.size() > 1) ? got_wr[1] : 64'hX, {32'h004, 32'hC0200880});
        load(1, "two_gap");

        img = '{8'h00, 8'h00, 8'h00};
        load(0, "empty");

        img = '{8'h01, 8'h01};
        load(0, "oversize");

        img = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h06, 8'hC0, 8'h20, 8'h08, 8'h80, 8'h4C};
        load(0, "badsum");
        img[10] = 8'h4D;
        load(0, "after_bad");

        // reset partway through the first data word
        got_wr.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(img[i], 0, ok);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_wr_en", 64'(wr_en), 64'd0);
        check("mid_rst_addr", 64'(wr_addr), 64'd0);
        check("mid_rst_data", 64'(wr_data), 64'd0);
        check("mid_rst_hold", 64'(cpu_hold), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_error", 64'(error), 64'd0);
        check("mid_rst_ready", 64'(byte_ready), 64'd0);
        repeat (2) @(negedge clk);
        check("mid_rst_writes", 64'(got_wr.size()), 64'd0);
        load(0, "post_rst");

        make_image(256, 1'b0, 1'b1);
        load(0, "full");
        check("full_last", (got_wr.size() > 0) ? got_wr[got_wr.size()-1] : 64'hX, {32'h3FC, 32'h000000FF});

        for (int t = 0; t < 14; t++) begin
            n = $urandom_range(0, 10);
            if ($urandom_range(0, 4) == 0) n = $urandom_range(257, 65535);
            make_image(n, ($urandom_range(0, 3) == 0), 1'b0);
            load(int'($urandom_range(0, 2)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
